// File: rtl/rsa_pkg.sv
// Shared constants and encodings for the RSA modular-exponentiation sequencer
// and its mod-stage handshake.
package rsa_pkg;

  localparam int RSA_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RELEASE,
    ST_CHK,
    ST_NEXT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_REDUCE,
    OP_MUL,
    OP_SQR
  } op_e;

endpackage

// File: rtl/mod_req_if.sv
// Request/acknowledge handshake towards the mod stage: latches one dividend per
// request, holds it with mod_start high, and acks on the first mod_done seen.
module mod_req_if #(
  parameter int BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic [2*BITS-1:0] dividend_i,
  input  logic [BITS-1:0]   mod_remainder_i,
  input  logic              mod_done_i,
  output logic [2*BITS-1:0] mod_dividend_o,
  output logic              mod_start_o,
  output logic [BITS-1:0]   remainder_o,
  output logic              ack_o
);

  logic              wait_q;
  logic [2*BITS-1:0] dividend_q;

  // mod_done only counts while a request is outstanding
  assign ack_o          = wait_q & mod_done_i;
  assign remainder_o    = mod_remainder_i;
  assign mod_start_o    = wait_q;
  assign mod_dividend_o = dividend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q     <= 1'b0;
      dividend_q <= '0;
    end else if (!wait_q && go_i) begin
      wait_q     <= 1'b1;
      dividend_q <= dividend_i;
    end else if (ack_o) begin
      wait_q     <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply sequencer computing base^exponent mod modulus
// by feeding full-width products to an external mod stage.
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int BITS = RSA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BITS-1:0]   base,
  input  logic [BITS-1:0]   exponent,
  input  logic [BITS-1:0]   modulus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BITS-1:0]   result,
  output logic [2*BITS-1:0] mod_dividend,
  output logic [BITS-1:0]   mod_divisor,
  output logic              mod_start,
  input  logic [BITS-1:0]   mod_remainder,
  input  logic              mod_done
);

  localparam int W2 = 2 * BITS;

  state_e          state_q;
  op_e             op_q;
  logic [BITS-1:0] acc_q, b_q, e_q, n_q, result_q;
  logic            busy_q, done_q, err_q;

  logic [BITS-1:0] mul_a, mul_b, rem;
  logic [W2-1:0]   dividend_d;
  logic            go, ack;

  always_comb begin
    mul_a      = acc_q;
    mul_b      = b_q;
    if (op_q == OP_SQR) mul_a = b_q;
    dividend_d = W2'(mul_a) * W2'(mul_b);
    if (op_q == OP_REDUCE) dividend_d = W2'(b_q);
  end

  assign go = (state_q == ST_REQ);

  mod_req_if #(.BITS(BITS)) u_req (
    .clk             (clk),
    .rst             (rst),
    .go_i            (go),
    .dividend_i      (dividend_d),
    .mod_remainder_i (mod_remainder),
    .mod_done_i      (mod_done),
    .mod_dividend_o  (mod_dividend),
    .mod_start_o     (mod_start),
    .remainder_o     (rem),
    .ack_o           (ack)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_REDUCE;
      acc_q    <= '0;
      b_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_q    <= modulus;
            e_q    <= exponent;
            b_q    <= base;
            op_q   <= OP_REDUCE;
            busy_q <= 1'b1;
            err_q  <= 1'b0;
            // modulus 0/1 short-circuits with a zero result
            if (modulus > BITS'(1)) begin
              acc_q   <= BITS'(1);
              state_q <= ST_REQ;
            end else begin
              acc_q   <= '0;
              state_q <= ST_DONE;
            end
          end
        end
        ST_REQ:     state_q <= ST_WAIT;
        ST_WAIT: begin
          if (ack) begin
            if (op_q == OP_MUL) acc_q <= rem;
            else                b_q   <= rem;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: state_q <= ST_CHK;
        ST_CHK: begin
          case (op_q)
            OP_MUL: begin
              // last bit consumed: the trailing square would be wasted
              if (e_q == BITS'(1)) begin
                state_q <= ST_DONE;
              end else begin
                op_q    <= OP_SQR;
                state_q <= ST_REQ;
              end
            end
            OP_SQR: begin
              e_q     <= e_q >> 1;
              state_q <= ST_NEXT;
            end
            default: state_q <= ST_NEXT;
          endcase
        end
        ST_NEXT: begin
          if (e_q == '0) begin
            state_q <= ST_DONE;
          end else if (e_q[0]) begin
            op_q    <= OP_MUL;
            state_q <= ST_REQ;
          end else if (e_q > BITS'(1)) begin
            op_q    <= OP_SQR;
            state_q <= ST_REQ;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_q <= acc_q;
          err_q    <= (n_q == '0);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign result      = result_q;
  assign mod_divisor = n_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl: a variable-latency mod-stage model plus
// an arithmetic reference for results and mod-request counts.
module tb_mod_exp_ctrl;

  localparam int BITS = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [BITS-1:0]   base = '0, exponent = '0, modulus = '0;
  logic              busy, done, err, mod_start;
  logic [BITS-1:0]   result, mod_divisor;
  logic [2*BITS-1:0] mod_dividend;
  logic [BITS-1:0]   mod_remainder = '0;
  logic              mod_done = 1'b0;

  int checks = 0;
  int failures = 0;

  int          req_cnt = 0;
  int          unstable_cnt = 0;
  int          lat = 0;
  logic        prev_start = 1'b0;
  logic [63:0] held_div = '0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.BITS(BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base          (base),
    .exponent      (exponent),
    .modulus       (modulus),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .result        (result),
    .mod_dividend  (mod_dividend),
    .mod_divisor   (mod_divisor),
    .mod_start     (mod_start),
    .mod_remainder (mod_remainder),
    .mod_done      (mod_done)
  );

  // Mod stage: random 1..40 cycle latency, holds done until start drops,
  // and throws stray done pulses with junk data while no request is open.
  always @(negedge clk) begin
    if (mod_start && !prev_start) begin
      req_cnt++;
      held_div = mod_dividend;
      lat      = $urandom_range(1, 40);
      mod_done = 1'b0;
    end else if (mod_start) begin
      if (mod_dividend !== held_div) unstable_cnt++;
      if (lat > 1) begin
        lat--;
        mod_done = 1'b0;
      end else begin
        mod_done      = 1'b1;
        mod_remainder = (mod_divisor == '0) ? '0 : 32'(held_div % {32'd0, mod_divisor});
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mod_done      = 1'b1;
      mod_remainder = $urandom;
    end else begin
      mod_done = 1'b0;
    end
    prev_start = mod_start;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                             input logic [31:0] n);
    logic [63:0] r, bb, nn;
    logic [31:0] ee;
    if (n <= 32'd1) return 32'd0;
    nn = {32'd0, n};
    r  = 64'd1;
    bb = {32'd0, b} % nn;
    ee = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * bb) % nn;
      bb = (bb * bb) % nn;
      ee = ee >> 1;
    end
    return r[31:0];
  endfunction

  function automatic int ref_reqs(input logic [31:0] e, input logic [31:0] n);
    int len;
    len = 0;
    if (n <= 32'd1) return 0;
    for (int i = 0; i < 32; i++) if (e[i]) len = i + 1;
    return 1 + $countones(e) + ((len > 0) ? len - 1 : 0);
  endfunction

  task automatic run_op(input string tag, input logic [31:0] b, input logic [31:0] e,
                        input logic [31:0] n, input logic [31:0] exp_res, input bit noise);
    int r0, u0, cyc;
    @(negedge clk);
    r0 = req_cnt;
    u0 = unstable_cnt;
    base = b; exponent = e; modulus = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 6000) begin
      if (noise && busy && $urandom_range(0, 15) == 0) begin
        start = 1'b1; base = $urandom; exponent = $urandom; modulus = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done"},   64'(done), 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    chk({tag, "_err"},    64'(err), 64'(n == 32'd0));
    chk({tag, "_idle"},   64'(busy), 64'd0);
    chk({tag, "_reqs"},   64'(req_cnt - r0), 64'(ref_reqs(e, n)));
    chk({tag, "_stable"}, 64'(unstable_cnt - u0), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"},  64'(done), 64'd0);
    chk({tag, "_hold"},   64'(result), 64'(exp_res));
  endtask

  initial begin
    logic [31:0] rb, re, rn;
    int cyc;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",    64'(busy), 64'd0);
    chk("rst_done",    64'(done), 64'd0);
    chk("rst_err",     64'(err), 64'd0);
    chk("rst_result",  64'(result), 64'd0);
    chk("rst_mstart",  64'(mod_start), 64'd0);
    chk("rst_mdiv",    mod_dividend, 64'd0);
    chk("rst_mdivsr",  64'(mod_divisor), 64'd0);
    rst = 1'b0;

    run_op("t4_13_497",   32'd4,    32'd13,   32'd497,  32'd445, 1'b1);
    run_op("enc65",       32'd65,   32'd17,   32'd3233, 32'd2790, 1'b1);
    run_op("dec2790",     32'd2790, 32'd2753, 32'd3233, 32'd65, 1'b1);
    run_op("exp0",        32'd5,    32'd0,    32'd7,    32'd1, 1'b0);
    run_op("mod1",        32'd123,  32'd456,  32'd1,    32'd0, 1'b0);
    run_op("mod0",        32'd9,    32'd9,    32'd0,    32'd0, 1'b0);
    run_op("errclr",      32'd3,    32'd5,    32'd7,    32'd5, 1'b0);
    run_op("exp1",        32'd10,   32'd1,    32'd7,    32'd3, 1'b0);
    run_op("exp2",        32'd10,   32'd2,    32'd7,    32'd2, 1'b0);

    for (int i = 0; i < 14; i++) begin
      rb = $urandom;
      re = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      rn = (i % 4 == 0) ? 32'($urandom_range(2, 1000)) : $urandom;
      run_op($sformatf("rnd%0d", i), rb, re, rn, ref_modexp(rb, re, rn), 1'b1);
    end

    // Abort mid-request, then confirm a clean restart
    @(negedge clk);
    base = 32'hDEADBEEF; exponent = 32'hFFFFFFFF; modulus = 32'hFFFFFFFB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!mod_start && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (5) begin
      @(negedge clk);
      if (!mod_start) cyc = 200;
    end
    chk("abort_in_wait", 64'(mod_start), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",   64'(busy), 64'd0);
    chk("abort_mstart", 64'(mod_start), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_done",   64'(done), 64'd0);
    run_op("after_rst", 32'd2, 32'd10, 32'd1000, 32'd24, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
